// File: rtl/lift_scheduler.sv
// lift_scheduler
//   Single-car lift scheduler using a SCAN (collective) policy. Outstanding
//   floor calls are latched. The travel direction is chosen only while the car
//   is idle. Each floor-to-floor move is timed, and the door handshake is
//   sequenced at every served floor.
//
//   Optional feature: define LIFT_ESTOP_EN to add the estop_i input. While
//   estop_i is high, the scheduler freezes in place.
//
// Ports
//   clk_i            system clock, all state on the rising edge
//   reset_i          asynchronous active-high reset
//   call_req_i       per-floor call buttons; a high bit latches that floor
//   door_open_i      door status from the door controller
//   estop_i          (LIFT_ESTOP_EN only) emergency stop, freezes the FSM
//   current_floor_o  floor the car is at, or last passed
//   moving_o         high while the car travels between floors
//   dir_up_o         current/last travel direction (1 = up)
//   arrive_pulse_o   one-cycle pulse on arrival at a served floor
//   door_reopen_o    one-cycle pulse asking the door to re-open/extend
//   pending_o        latched outstanding calls
//   door_fault_o     sticky flag, set when the door handshake times out
module lift_scheduler #(
    parameter  int N_FLOORS            = 8,
    parameter  int FLOOR_TRAVEL_CYCLES = 100,
    parameter  int DOOR_TIMEOUT_CYCLES = 1024,
    localparam int FW                  = (N_FLOORS > 2) ? $clog2(N_FLOORS) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_FLOORS-1:0] call_req_i,
    input  logic                door_open_i,
`ifdef LIFT_ESTOP_EN
    input  logic                estop_i,
`endif
    output logic [FW-1:0]       current_floor_o,
    output logic                moving_o,
    output logic                dir_up_o,
    output logic                arrive_pulse_o,
    output logic                door_reopen_o,
    output logic [N_FLOORS-1:0] pending_o,
    output logic                door_fault_o
);

    localparam int TW = $clog2(FLOOR_TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR   = FW'(N_FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR_WAIT} state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  step_q, step_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic                  phase_q, phase_d;
    logic                  fault_q, fault_d;
    logic                  arrive_q, arrive_d;
    logic                  reopen_q, reopen_d;
    logic                  moving_q, moving_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d;

    logic [N_FLOORS-1:0]   floor_onehot;
    logic [N_FLOORS-1:0]   clear_mask;
    logic [N_FLOORS-1:0]   block_mask;
    logic                  ahead_up, ahead_dn, call_hit, at_end;
    logic                  freeze, estop_rise;

    // While frozen, the whole FSM holds. estop_rise provides the single
    // door_reopen pulse that is issued when estop lands during DOOR_WAIT.
`ifdef LIFT_ESTOP_EN
    logic estop_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) estop_q <= 1'b0;
        else         estop_q <= estop_i;
    end
    assign freeze     = estop_i;
    assign estop_rise = estop_i & ~estop_q;
`else
    assign freeze     = 1'b0;
    assign estop_rise = 1'b0;
`endif

    assign floor_onehot = N_FLOORS'(1) << floor_q;
    assign call_hit     = (state_q == DOOR_WAIT) && call_req_i[floor_q];
    assign block_mask   = (state_q == DOOR_WAIT) ? floor_onehot : '0;
    assign at_end       = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);

    // Look for outstanding calls above and below the car's floor.
    always_comb begin
        ahead_up = 1'b0;
        ahead_dn = 1'b0;
        for (int f = 0; f < N_FLOORS; f++) begin
            if (pending_q[f] && (FW'(f) > floor_q)) ahead_up = 1'b1;
            if (pending_q[f] && (FW'(f) < floor_q)) ahead_dn = 1'b1;
        end
    end

    // Next-state logic. In MOVE, the cycle right after a floor step (step_q)
    // is used to decide at the new floor whether to stop, park at an end
    // floor, or keep travelling. Each floor therefore costs
    // FLOOR_TRAVEL_CYCLES+1 cycles.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        tcnt_d     = tcnt_q;
        step_d     = step_q;
        dcnt_d     = dcnt_q;
        phase_d    = phase_q;
        fault_d    = fault_q;
        reopen_d   = 1'b0;
        clear_mask = '0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                step_d = 1'b0;
                if (pending_q[floor_q]) begin
                    state_d = ARRIVE;
                end else if (dir_q ? ahead_up : ahead_dn) begin
                    state_d = MOVE;
                end else if (dir_q ? ahead_dn : ahead_up) begin
                    dir_d   = ~dir_q;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (step_q) begin
                    step_d = 1'b0;
                    if (pending_q[floor_q]) state_d = ARRIVE;
                    else if (at_end)        state_d = IDLE;
                end else if (tcnt_q == TRAVEL_LAST) begin
                    tcnt_d = '0;
                    step_d = 1'b1;
                    if (dir_q && floor_q != TOP_FLOOR)  floor_d = floor_q + 1'b1;
                    else if (!dir_q && floor_q != '0)   floor_d = floor_q - 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ARRIVE: begin
                clear_mask = floor_onehot;
                dcnt_d     = '0;
                phase_d    = 1'b0;
                state_d    = DOOR_WAIT;
            end
            DOOR_WAIT: begin
                // A call at this floor extends the door instead of latching.
                // The pulse is rate-limited to one every two cycles.
                if (call_hit) begin
                    dcnt_d   = '0;
                    reopen_d = ~reopen_q;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
                if (!call_hit && dcnt_q == DOOR_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else if (!phase_q) begin
                    if (door_open_i) phase_d = 1'b1;
                end else if (!door_open_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        arrive_d = (state_d == ARRIVE);

        if (freeze) begin
            state_d    = state_q;
            floor_d    = floor_q;
            dir_d      = dir_q;
            tcnt_d     = tcnt_q;
            step_d     = step_q;
            dcnt_d     = dcnt_q;
            phase_d    = phase_q;
            fault_d    = fault_q;
            arrive_d   = 1'b0;
            clear_mask = '0;
            reopen_d   = estop_rise && (state_q == DOOR_WAIT);
        end

        moving_d  = (state_d == MOVE) && !freeze;
        pending_d = (pending_q | (call_req_i & ~block_mask)) & ~clear_mask;
    end

    // All state and all outputs are registered here. Reset returns
    // everything to the parked state, so pending calls are dropped.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_q     <= 1'b1;
            tcnt_q    <= '0;
            step_q    <= 1'b0;
            dcnt_q    <= '0;
            phase_q   <= 1'b0;
            fault_q   <= 1'b0;
            arrive_q  <= 1'b0;
            reopen_q  <= 1'b0;
            moving_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            tcnt_q    <= tcnt_d;
            step_q    <= step_d;
            dcnt_q    <= dcnt_d;
            phase_q   <= phase_d;
            fault_q   <= fault_d;
            arrive_q  <= arrive_d;
            reopen_q  <= reopen_d;
            moving_q  <= moving_d;
            pending_q <= pending_d;
        end
    end

    assign current_floor_o = floor_q;
    assign moving_o        = moving_q;
    assign dir_up_o        = dir_q;
    assign arrive_pulse_o  = arrive_q;
    assign door_reopen_o   = reopen_q;
    assign pending_o       = pending_q;
    assign door_fault_o    = fault_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler
//   Bench for lift_scheduler. Directed scenarios exercise travel timing, the
//   door handshake, re-open, timeout and asynchronous reset. Random call sets
//   are checked against a SCAN service-order model.
module tb_lift_scheduler;

    localparam int N  = 8;
    localparam int T  = 100;
    localparam int TO = 1024;
    localparam int FW = 3;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [N-1:0]  call_req  = '0;
    logic          door_open = 1'b0;
    logic [FW-1:0] current_floor;
    logic          moving, dir_up, arrive_pulse, door_reopen, door_fault;
    logic [N-1:0]  pending;

    int errors = 0;
    int checks = 0;
    int model_floor;
    bit model_dir;

    lift_scheduler #(
        .N_FLOORS(N), .FLOOR_TRAVEL_CYCLES(T), .DOOR_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .call_req_i     (call_req),
        .door_open_i    (door_open),
`ifdef LIFT_ESTOP_EN
        .estop_i        (1'b0),
`endif
        .current_floor_o(current_floor),
        .moving_o       (moving),
        .dir_up_o       (dir_up),
        .arrive_pulse_o (arrive_pulse),
        .door_reopen_o  (door_reopen),
        .pending_o      (pending),
        .door_fault_o   (door_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_arrive(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (arrive_pulse === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic serve_door();
        door_open = 1'b1;
        repeat (3) tick();
        door_open = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; call_req = '0; door_open = 1'b0;
        repeat (3) tick();
        checks++;
        if ({current_floor, moving, dir_up, arrive_pulse, door_reopen, door_fault, pending}
            !== {{FW{1'b0}}, 5'b01000, {N{1'b0}}}) begin
            $display("[TB] FAIL reset_held: actual=%h required=%h",
                     {current_floor, moving, dir_up, arrive_pulse, door_reopen, door_fault, pending},
                     {{FW{1'b0}}, 5'b01000, {N{1'b0}}});
            errors++;
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({current_floor, moving, dir_up, arrive_pulse, door_reopen, door_fault, pending}
            !== {{FW{1'b0}}, 5'b01000, {N{1'b0}}}) begin
            $display("[TB] FAIL reset_release: actual=%h required=%h",
                     {current_floor, moving, dir_up, arrive_pulse, door_reopen, door_fault, pending},
                     {{FW{1'b0}}, 5'b01000, {N{1'b0}}});
            errors++;
        end
        model_floor = 0;
        model_dir   = 1'b1;
    endtask

    // Call to floor 3 from floor 0: each floor takes T+1 cycles after the call.
    task automatic test_single_call();
        int exp_floor;
        call_req = N'(1) << 3;
        tick();
        call_req = '0;
        for (int e = 1; e <= 303; e++) begin
            tick();
            exp_floor = (e / (T + 1) > 3) ? 3 : e / (T + 1);
            checks++;
            if (current_floor !== FW'(exp_floor) || moving !== 1'b1) begin
                $display("[TB] FAIL travel_e%0d: actual floor=%0d moving=%b required floor=%0d moving=1",
                         e, current_floor, moving, exp_floor);
                errors++;
            end
            if (e == 1) begin
                checks++;
                if (dir_up !== 1'b1) begin
                    $display("[TB] FAIL start_dir: actual=%b required=1", dir_up);
                    errors++;
                end
            end
        end
        tick();
        checks++;
        if (arrive_pulse !== 1'b1 || moving !== 1'b0) begin
            $display("[TB] FAIL arrive_3: actual arrive=%b moving=%b required arrive=1 moving=0",
                     arrive_pulse, moving);
            errors++;
        end
        tick();
        checks++;
        if (arrive_pulse !== 1'b0 || pending[3] !== 1'b0) begin
            $display("[TB] FAIL arrive_end_3: actual arrive=%b pending3=%b required 0 0",
                     arrive_pulse, pending[3]);
            errors++;
        end
        serve_door();
        model_floor = 3;
    endtask

    // Round 0 is the sweep case (car at 3 going up, calls at 1 and 6); later
    // rounds use random call sets. The SCAN order is: the current floor, then
    // the calls ahead in the current direction, then the rest on the way back.
    task automatic test_scan(input int rounds);
        logic [N-1:0] mask;
        int           exp_q[$];
        bit           ok, any_up, any_dn;
        for (int r = 0; r < rounds; r++) begin
            if (r == 0) mask = 8'b0100_0010;
            else        mask = N'($urandom_range(1, (1 << N) - 1));
            exp_q  = {};
            any_up = 1'b0;
            any_dn = 1'b0;
            for (int f = 0; f < N; f++) begin
                if (mask[f] && f > model_floor) any_up = 1'b1;
                if (mask[f] && f < model_floor) any_dn = 1'b1;
            end
            if (mask[model_floor]) exp_q.push_back(model_floor);
            if (model_dir) begin
                for (int f = model_floor + 1; f < N; f++) if (mask[f]) exp_q.push_back(f);
                for (int f = model_floor - 1; f >= 0; f--) if (mask[f]) exp_q.push_back(f);
            end else begin
                for (int f = model_floor - 1; f >= 0; f--) if (mask[f]) exp_q.push_back(f);
                for (int f = model_floor + 1; f < N; f++) if (mask[f]) exp_q.push_back(f);
            end
            call_req = mask;
            tick();
            call_req = '0;
            foreach (exp_q[k]) begin
                wait_arrive(N * (T + 1) + 20, ok);
                checks++;
                if (!ok) begin
                    $display("[TB] FAIL scan_r%0d_stop%0d: actual=no arrival required=floor %0d",
                             r, k, exp_q[k]);
                    errors++;
                end else if (current_floor !== FW'(exp_q[k])) begin
                    $display("[TB] FAIL scan_r%0d_stop%0d: actual floor=%0d required floor=%0d",
                             r, k, current_floor, exp_q[k]);
                    errors++;
                end
                door_open = 1'b1;
                tick();
                checks++;
                if (pending[exp_q[k]] !== 1'b0) begin
                    $display("[TB] FAIL scan_clear_r%0d: actual pending=%b required bit %0d clear",
                             r, pending, exp_q[k]);
                    errors++;
                end
                repeat (2) tick();
                door_open = 1'b0;
                repeat (2) tick();
            end
            if (model_dir) model_dir = !any_dn;
            else           model_dir = any_up;
            model_floor = exp_q[exp_q.size() - 1];
            checks++;
            if (dir_up !== model_dir || pending !== '0 || moving !== 1'b0) begin
                $display("[TB] FAIL scan_end_r%0d: actual dir=%b pending=%b moving=%b required dir=%b pending=0 moving=0",
                         r, dir_up, pending, moving, model_dir);
                errors++;
            end
        end
    endtask

    task automatic test_same_floor();
        call_req = N'(1) << model_floor;
        tick();
        call_req = '0;
        checks++;
        if (pending[model_floor] !== 1'b1) begin
            $display("[TB] FAIL same_latch: actual=%b required=1", pending[model_floor]);
            errors++;
        end
        tick();
        checks++;
        if (arrive_pulse !== 1'b1 || moving !== 1'b0 || current_floor !== FW'(model_floor)) begin
            $display("[TB] FAIL same_arrive: actual arrive=%b moving=%b floor=%0d required 1 0 %0d",
                     arrive_pulse, moving, current_floor, model_floor);
            errors++;
        end
        serve_door();
    endtask

    // The door is held open while a call at the same floor is made for two
    // cycles. The call must produce one re-open pulse, must not latch, and
    // must restart the door timeout from the last call cycle.
    task automatic test_door_reopen();
        call_req = N'(1) << model_floor;
        tick();
        call_req = '0;
        tick();
        door_open = 1'b1;
        repeat (10) tick();
        call_req = N'(1) << model_floor;
        tick();
        checks++;
        if (door_reopen !== 1'b1) begin
            $display("[TB] FAIL reopen_pulse: actual=%b required=1", door_reopen);
            errors++;
        end
        tick();
        call_req = '0;
        checks++;
        if (door_reopen !== 1'b0 || pending[model_floor] !== 1'b0) begin
            $display("[TB] FAIL reopen_limit: actual reopen=%b pending=%b required 0 0",
                     door_reopen, pending[model_floor]);
            errors++;
        end
        repeat (TO - 1) tick();
        checks++;
        if (door_fault !== 1'b0) begin
            $display("[TB] FAIL reopen_restart: actual fault=%b required=0", door_fault);
            errors++;
        end
        tick();
        checks++;
        if (door_fault !== 1'b1) begin
            $display("[TB] FAIL reopen_timeout: actual fault=%b required=1", door_fault);
            errors++;
        end
        door_open = 1'b0;
        tick();
    endtask

    task automatic test_door_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        model_floor = 0;
        model_dir   = 1'b1;
        call_req = N'(1);
        tick();
        call_req = '0;
        tick();
        checks++;
        if (arrive_pulse !== 1'b1) begin
            $display("[TB] FAIL timeout_arrive: actual=%b required=1", arrive_pulse);
            errors++;
        end
        repeat (TO) tick();
        checks++;
        if (door_fault !== 1'b0) begin
            $display("[TB] FAIL timeout_early: actual fault=%b required=0", door_fault);
            errors++;
        end
        tick();
        checks++;
        if (door_fault !== 1'b1) begin
            $display("[TB] FAIL timeout_fault: actual fault=%b required=1", door_fault);
            errors++;
        end
        // Back in IDLE: a same-floor call is served on the next cycle.
        call_req = N'(1);
        tick();
        call_req = '0;
        tick();
        checks++;
        if (arrive_pulse !== 1'b1 || door_fault !== 1'b1) begin
            $display("[TB] FAIL timeout_idle: actual arrive=%b fault=%b required 1 1",
                     arrive_pulse, door_fault);
            errors++;
        end
        serve_door();
    endtask

    task automatic test_async_reset();
        call_req = N'(1) << 3;
        tick();
        call_req = '0;
        repeat (150) tick();
        checks++;
        if (current_floor !== FW'(1) || moving !== 1'b1) begin
            $display("[TB] FAIL mid_move: actual floor=%0d moving=%b required 1 1",
                     current_floor, moving);
            errors++;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({current_floor, moving, dir_up, arrive_pulse, door_reopen, door_fault, pending}
            !== {{FW{1'b0}}, 5'b01000, {N{1'b0}}}) begin
            $display("[TB] FAIL async_reset: actual=%h required=%h",
                     {current_floor, moving, dir_up, arrive_pulse, door_reopen, door_fault, pending},
                     {{FW{1'b0}}, 5'b01000, {N{1'b0}}});
            errors++;
        end
        tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (pending !== '0 || moving !== 1'b0 || current_floor !== '0) begin
            $display("[TB] FAIL reset_lost: actual pending=%b moving=%b floor=%0d required 0 0 0",
                     pending, moving, current_floor);
            errors++;
        end
        model_floor = 0;
        model_dir   = 1'b1;
    endtask

    initial begin
        $display("[TB] lift_scheduler bench start");
        test_reset();
        test_single_call();
        test_scan(7);
        test_same_floor();
        test_door_reopen();
        test_door_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lift_scheduler.md
Name: lift_scheduler

Overview:
- Single-car lift scheduler: latches floor calls, picks travel direction (SCAN / collective policy), times floor-to-floor travel, and sequences the door at each served floor.
- Sits between the call-button inputs and the door controller. Its arrive_pulse drives the door controller's edge input; door_reopen drives force_open; it watches door_open to know when the car may leave.

Parameters:
- N_FLOORS, 8, number of floors (>=2); floors are indexed 0..N_FLOORS-1.
- FLOOR_TRAVEL_CYCLES, 100, clock cycles to move one floor (>=1).
- DOOR_TIMEOUT_CYCLES, 1024, maximum cycles spent in DOOR_WAIT before forcing progress.
- FW, $clog2(N_FLOORS) (minimum 1), width of a floor index. Derived; never overridden.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  N_FLOORS  per-floor call; a high bit in any cycle sets that floor's pending bit.
- door_open  in  1  status from the door controller.
- current_floor  out  FW  floor the car is at, or last passed.
- moving  out  1  high while in MOVE.
- dir_up  out  1  current/last travel direction (1 = up).
- arrive_pulse  out  1  one-cycle pulse on arrival at a served floor.
- door_reopen  out  1  one-cycle pulse requesting a door re-open/extend.
- pending  out  N_FLOORS  latched outstanding calls.
- door_fault  out  1  sticky; set on a DOOR_WAIT timeout.

Behaviour:
- Reset values (asynchronous): state=IDLE, current_floor=0, dir_up=1, pending=0, all pulses 0, door_fault=0, counters 0.
- pending: each cycle pending <= (pending | call_req) & ~clear_mask. clear_mask is the current_floor bit in the ARRIVE cycle only, so clear wins over a set on the same floor in that cycle.
- ahead_up = any pending bit above current_floor; ahead_dn = any pending bit below current_floor.

States:
- IDLE:
  - Pending bit at current_floor set -> ARRIVE.
  - Else if ahead in dir_up's direction -> MOVE, keeping dir_up.
  - Else if ahead in the opposite direction -> flip dir_up, then MOVE.
  - Else stay in IDLE.
- MOVE:
  - Counter counts 0..FLOOR_TRAVEL_CYCLES-1.
  - At terminal count: current_floor +/- 1 and counter returns to 0.
  - If the new floor is pending -> ARRIVE; else continue.
  - current_floor saturates at 0 and at N_FLOORS-1. Reaching an end floor with nothing pending there -> IDLE.
  - Latency from call to first floor step: FLOOR_TRAVEL_CYCLES+1 cycles from IDLE.
- ARRIVE (1 cycle): assert arrive_pulse, clear the current_floor pending bit, -> DOOR_WAIT.
- DOOR_WAIT:
  - Sub-phase A: wait for door_open==1.
  - Sub-phase B: wait for door_open==0, then -> IDLE.
  - A call_req on current_floor during DOOR_WAIT does not set pending. It pulses door_reopen for 1 cycle (at most once per 2 cycles) and restarts the timeout.
  - Timeout counter reaching DOOR_TIMEOUT_CYCLES -> set door_fault, -> IDLE.
- Direction reversal happens only in IDLE, never mid-MOVE.
- Reset mid-MOVE or mid-DOOR_WAIT: immediate return to reset values; pending calls are lost.
- moving==1 exactly when state==MOVE. Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro LIFT_ESTOP_EN.
- Defined: adds input estop (1 bit).
  - While estop is high: the state machine freezes, the travel counter holds, moving=0, and no pulses are issued. pending still accepts calls.
  - On release: resumes the same state with the held count.
  - estop high in DOOR_WAIT: door_reopen is pulsed once.
- Undefined: no estop port and no freeze logic.

Test Plan:
- Reset, then call_req[3] for one cycle -> moving=1 and dir_up=1. current_floor steps to 1, 2, 3 at 101, 202 and 303 cycles after the call. Then arrive_pulse for 1 cycle and pending[3] cleared.
- Car at 3, IDLE, dir_up=1. call_req[1] and call_req[6] in the same cycle -> serves 6 first, then IDLE, dir_up flips to 0, then serves 1.
- Car idle at floor 2, call_req[2] -> ARRIVE on the next cycle, arrive_pulse, no MOVE.
- DOOR_WAIT at floor 4 with door_open held high, call_req[4] -> door_reopen pulse, pending[4] stays 0, timeout restarts.
- door_open held at 0 after arrival -> door_fault=1 at DOOR_TIMEOUT_CYCLES (1024), state returns to IDLE.
- Reset asserted asynchronously mid-MOVE between floors 1 and 2 -> all outputs return to reset values immediately, before the next clock edge.
